disp_timing_ctrl: RTL and testbench

DISP_TIMING_CTRL -- requirements
Module: disp_timing_ctrl

---
 rtl/disp_timing_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_disp_timing_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_timing_ctrl.sv
// Display timing controller: panel power sequencing, pixel clock,
// sync/DEN generation and active-area coordinates for a parallel RGB panel.
module disp_timing_ctrl #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int PWR_DLY  = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       enable,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DEN,
  output logic       DISP_CLK,
  output logic       DISP_EN,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       status
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DW      = $clog2(PWR_DLY + 1);

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA_BEG = 11'(H_SYNC + H_BP);
  localparam logic [10:0] VA_BEG = 11'(V_SYNC + V_BP);
  localparam logic [10:0] HA_END = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] VA_END = 11'(V_SYNC + V_BP + V_ACTIVE);

  // Power-up holds one extra cycle so RUN starts on a DISP_CLK high phase.
  localparam logic [DW-1:0] UP_END = DW'(PWR_DLY);
  localparam logic [DW-1:0] DN_END = DW'(PWR_DLY - 1);

  typedef enum logic [1:0] {
    OFF,
    PWR_UP,
    RUN,
    PWR_DN
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          stop_q, stop_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic          dclk_q, dclk_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          den_q, den_d;
  logic          en_q, en_d;
  logic          fs_q, fs_d;
  logic [9:0]    px_q, px_d;
  logic [9:0]    py_q, py_d;

  logic          tick;
  logic          last;
  logic          run_d;
  logic          h_act;
  logic          v_act;
  logic [10:0]   hx;
  logic [10:0]   vx;

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    tick    = (state_q == RUN) && dclk_q;
    last    = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    unique case (state_q)
      OFF: begin
        if (enable) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (!enable)              state_d = OFF;
        else if (dly_q == UP_END) state_d = RUN;
      end
      RUN: begin
        stop_d = ~enable;
        if (tick && last && stop_q) state_d = PWR_DN;
      end
      PWR_DN: begin
        if (dly_q == DN_END) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
    if (state_d != RUN) stop_d = 1'b0;
  end

  always_comb begin
    dly_d = '0;
    if ((state_d == state_q) &&
        ((state_q == PWR_UP) || (state_q == PWR_DN)))
      dly_d = dly_q + 1'b1;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    if (state_d != RUN) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  // Decode from next counts so every output lands on the counter edge.
  always_comb begin
    run_d  = (state_d == RUN);
    hx     = {1'b0, hcnt_d};
    vx     = {1'b0, vcnt_d};
    h_act  = (hx >= HA_BEG) && (hx < HA_END);
    v_act  = (vx >= VA_BEG) && (vx < VA_END);
    dclk_d = (state_q != OFF) && (state_d != OFF) && !dclk_q;
    hs_d   = !(run_d && (hx < HS_END));
    vs_d   = !(run_d && (vx < VS_END));
    den_d  = run_d && h_act && v_act;
    px_d   = den_d ? 10'(hx - HA_BEG) : '0;
    py_d   = den_d ? 10'(vx - VA_BEG) : '0;
    en_d   = run_d;
    fs_d   = run_d && ((state_q != RUN) ||
             (tick && (hcnt_d == '0) && (vcnt_d == '0)));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= OFF;
      dly_q   <= '0;
      stop_q  <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      dclk_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      den_q   <= 1'b0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      stop_q  <= stop_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      dclk_q  <= dclk_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      den_q   <= den_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign DEN         = den_q;
  assign DISP_CLK    = dclk_q;
  assign DISP_EN     = en_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign frame_start = fs_q;
  assign status      = en_q;

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Scoreboard bench for disp_timing_ctrl: timed expectations are queued
// as stimulus is planned and compared as each Clk edge completes.
module tb_disp_timing_ctrl;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int PD = 8;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b0;
  logic       HSYNC;
  logic       VSYNC;
  logic       DEN;
  logic       DISP_CLK;
  logic       DISP_EN;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;
  logic       status;

  disp_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PWR_DLY(PD)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .enable(enable),
    .HSYNC(HSYNC),
    .VSYNC(VSYNC),
    .DEN(DEN),
    .DISP_CLK(DISP_CLK),
    .DISP_EN(DISP_EN),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .frame_start(frame_start),
    .status(status)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t  sbq[$];
  string sname[9] = '{"hsync", "vsync", "den", "dclk", "disp_en",
                      "pix_x", "pix_y", "fstart", "status"};

  int edge_n  = 0;
  int checks  = 0;
  int failures = 0;
  int fs_n    = 0;
  int fs_at[4] = '{default: 0};
  int den_cnt = 0;
  int hs_lo   = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int dut_sig(int s);
    case (s)
      0: return int'(HSYNC);
      1: return int'(VSYNC);
      2: return int'(DEN);
      3: return int'(DISP_CLK);
      4: return int'(DISP_EN);
      5: return int'(pix_x);
      6: return int'(pix_y);
      7: return int'(frame_start);
      8: return int'(status);
      default: return -1;
    endcase
  endfunction

  function automatic void push(int c, int s, int v, string t);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = $sformatf("%s.%s@%0d", t, sname[s], c);
    sbq.push_back(e);
  endfunction

  function automatic void push_all(int c, string t, int hs, int vs,
                                   int de, int dc, int en, int px,
                                   int py, int fs, int st);
    push(c, 0, hs, t);
    push(c, 1, vs, t);
    push(c, 2, de, t);
    push(c, 3, dc, t);
    push(c, 4, en, t);
    push(c, 5, px, t);
    push(c, 6, py, t);
    push(c, 7, fs, t);
    push(c, 8, st, t);
  endfunction

  function automatic void push_idle(int c, string t, int dc);
    push_all(c, t, 1, 1, 0, dc, 0, 0, 0, 0, 0);
  endfunction

  // Enable sampled at e0; DISP_CLK runs from e0+1, RUN begins at e0+PD+1.
  function automatic void push_up(int e0, string t);
    push_idle(e0, t, 0);
    for (int k = 1; k <= PD; k++) push_idle(e0 + k, t, k % 2);
  endfunction

  // k = Clk edges since RUN entry; first pixel tick is one edge later.
  function automatic void push_run(int base, int k, string t);
    int n, h, v, de, fs;
    n  = (k + 1) / 2;
    h  = n % HT;
    v  = (n / HT) % VT;
    de = (h >= HS + HB && h < HS + HB + HA &&
          v >= VS + VB && v < VS + VB + VA) ? 1 : 0;
    fs = (k == 0 || (k % 2 == 1 && n % (HT * VT) == 0)) ? 1 : 0;
    push_all(base + k, t, (h >= HS) ? 1 : 0, (v >= VS) ? 1 : 0, de,
             (k % 2 == 0) ? 1 : 0, 1, de ? h - HS - HB : 0,
             de ? v - VS - VB : 0, fs, 1);
  endfunction

  always @(posedge Clk) begin
    edge_n++;
    #1;
    if (frame_start) begin
      fs_n++;
      if (fs_n <= 3) fs_at[fs_n] = edge_n;
    end
    if (fs_n == 2) begin
      den_cnt += int'(DEN);
      hs_lo   += int'(!HSYNC);
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == edge_n) begin
        chk(sbq[i].tag, dut_sig(sbq[i].sig), sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic to_neg(int e);
    while (edge_n < e) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, e, f0, g0, r;

    for (int c = 1; c <= 55; c++) push_idle(c, "rst", 0);
    to_neg(50);
    Reset = 1'b0;

    e0 = 56;
    to_neg(e0 - 1);
    push_up(e0, "up");
    for (int k = 0; k < 287; k++) push_run(e0 + PD + 1, k, "run");
    e = e0 + PD + 1 + 287;
    push_idle(e, "dn", 0);
    for (int k = 1; k <= PD; k++) push_idle(e + k, "dn", k % 2);
    for (int c = e + PD + 1; c <= e + 20; c++) push_idle(c, "off", 0);
    enable = 1'b1;
    to_neg(e0 + PD + 1 + 230);
    enable = 1'b0;
    to_neg(e + 20);
    chk("fs_gap", fs_at[3] - fs_at[2], HT * VT * 2);
    chk("den_clks", den_cnt, VA * HA * 2);
    chk("hsync_lo_clks", hs_lo, VT * HS * 2);

    f0 = e + 21;
    push_idle(f0, "abort", 0);
    for (int k = 1; k <= 3; k++) push_idle(f0 + k, "abort", k % 2);
    for (int c = f0 + 4; c <= f0 + 20; c++) push_idle(c, "abort", 0);
    enable = 1'b1;
    to_neg(f0 + 3);
    enable = 1'b0;
    to_neg(f0 + 20);

    g0 = f0 + 21;
    push_up(g0, "up2");
    for (int k = 0; k <= 40; k++) push_run(g0 + PD + 1, k, "run2");
    r = g0 + PD + 1 + 41;
    push_idle(r, "rst_run", 0);
    for (int c = r + 1; c <= r + 5; c++) push_idle(c, "post_rst", 0);
    enable = 1'b1;
    to_neg(r - 1);
    Reset = 1'b1;
    to_neg(r);
    Reset  = 1'b0;
    enable = 1'b0;
    to_neg(r + 5);

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
